// File: rtl/dfp_line_mem_pkg.sv
// Shared types for the dfp line memory: line geometry, FSM states and latched op.
package dfp_mem_types;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;
endpackage

// File: rtl/dfp_line_mem_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, reloads seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;
endmodule

// File: rtl/dfp_line_mem.sv
// Line-granular backing memory answering the cache's dfp interface, one transaction at a time.
// Define DFP_LINE_MEM_RAND_LAT_EN to add 0..7 cycles of LFSR-driven jitter to each latency.
module dfp_line_mem
  import dfp_mem_types::*;
#(
  parameter int          IDX_W     = 8,
  parameter int          LAT       = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic         err
);
  localparam int CNT_W = 9;

  mem_state_t          state_q, state_d;
  mem_op_t             op_q, op_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [LINE_W-1:0]   mem [2**IDX_W];
  logic [IDX_W-1:0]    rd_idx;
  logic [LINE_W-1:0]   mem_rdata;
  logic [CNT_W-1:0]    lat_now;
  logic                held, other, mem_we;

`ifdef DFP_LINE_MEM_RAND_LAT_EN
  logic [15:0] lfsr_out;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr_out)
  );
  assign lat_now     = CNT_W'(LAT) + {{(CNT_W-3){1'b0}}, lfsr_out[2:0]};
  assign unused_lfsr = ^lfsr_out[15:3];
`else
  logic unused_seed;
  assign lat_now     = CNT_W'(LAT);
  assign unused_seed = ^LFSR_SEED;
`endif

  // In IDLE the read may complete in the acceptance cycle (latency 1), so index from the live address.
  assign rd_idx    = (state_q == IDLE) ? dfp_addr[OFFSET_W +: IDX_W] : addr_q[OFFSET_W +: IDX_W];
  assign mem_rdata = mem[rd_idx];
  assign held      = (op_q == OP_WRITE) ? dfp_write : dfp_read;
  assign other     = (op_q == OP_WRITE) ? dfp_read  : dfp_write;
  assign mem_we    = (state_q == RESP) && (op_q == OP_WRITE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (dfp_read && dfp_write) begin
          err_d = 1'b1;
        end else if (dfp_read || dfp_write) begin
          op_d    = dfp_write ? OP_WRITE : OP_READ;
          addr_d  = dfp_addr;
          wdata_d = dfp_wdata;
          cnt_d   = lat_now - 1'b1;
          if (lat_now == CNT_W'(1)) begin
            state_d = RESP;
            if (!dfp_write) rdata_d = mem_rdata;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!held) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (other || (dfp_addr != addr_q) || (dfp_wdata != wdata_q)) err_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) begin
            state_d = RESP;
            if (op_q == OP_READ) rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately unreset; rst still blocks a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr_q[OFFSET_W +: IDX_W]] <= wdata_q;
  end

  assign dfp_rdata = rdata_q;
  assign dfp_resp  = (state_q == RESP);
  assign err       = err_q;
endmodule
